// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multi-cycle MIPS core: sequences the shared datapath per opcode.
// Optional bne support is compiled in with `define MC_MAIN_CTRL_BNE_EN.
module mc_main_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StAluWb  = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StAddiEx = 4'd9;
  localparam logic [3:0] StAddiWb = 4'd10;
  localparam logic [3:0] StJump   = 4'd11;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_MAIN_CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  localparam bit         TimeoutEn = (WAIT_LIMIT != 0);
  localparam logic [7:0] LimitM1   = TimeoutEn ? 8'(WAIT_LIMIT - 1) : 8'd0;

  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_wait;
  logic       timeout;

  // Only the states that issue a memory access can stall on mem_ready.
  assign mem_wait = ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr)) &&
                    !mem_ready;
  assign timeout  = TimeoutEn && mem_wait && (cnt_q == LimitM1);
  assign state    = state_q;

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_op      = 2'b00;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      StFetch: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
`ifdef MC_MAIN_CTRL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
`ifdef MC_MAIN_CTRL_BNE_EN
        branch    = (opcode != OpBne);
        branch_ne = (opcode == OpBne);
`else
        branch    = 1'b1;
`endif
        state_d   = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Abort the stalled access: suppress its strobes and restart from fetch.
    if (timeout) begin
      state_d     = StFetch;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      mem_write   = 1'b0;
      mem_timeout = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || mem_ready || timeout) begin
      cnt_d = 8'd0;
    end else if (mem_wait) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
